// File: rtl/bus_arbiter.sv
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Two-master (instruction fetch / data) to one-slave bus arbiter
//             with alternating fairness on contention.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    input  logic [2:0]        ireq_size,
    output logic              iresp_addr_ok,
    output logic              iresp_data_ok,
    output logic [DATA_W-1:0] iresp_data,

    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [7:0]        dreq_strobe,
    input  logic [DATA_W-1:0] dreq_data,
    output logic              dresp_addr_ok,
    output logic              dresp_data_ok,
    output logic [DATA_W-1:0] dresp_data,

    output logic              oreq_valid,
    output logic [ADDR_W-1:0] oreq_addr,
    output logic [2:0]        oreq_size,
    output logic [7:0]        oreq_strobe,
    output logic [DATA_W-1:0] oreq_data,
    input  logic              oresp_addr_ok,
    input  logic              oresp_data_ok,
    input  logic [DATA_W-1:0] oresp_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2
    } state_t;

    localparam logic c_LAST_I = 1'b0;
    localparam logic c_LAST_D = 1'b1;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last_grant;
    logic   w_last_grant_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_LAST_I;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Contention goes to whichever master did not complete most recently.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (ireq_valid && dreq_valid) begin
                    w_state_nxt = (r_last_grant == c_LAST_I) ? S_GRANT_D : S_GRANT_I;
                end else if (ireq_valid) begin
                    w_state_nxt = S_GRANT_I;
                end else if (dreq_valid) begin
                    w_state_nxt = S_GRANT_D;
                end
            end
            S_GRANT_I: begin
                if (oresp_data_ok) begin
                    w_state_nxt      = S_IDLE;
                    w_last_grant_nxt = c_LAST_I;
                end
            end
            S_GRANT_D: begin
                if (oresp_data_ok) begin
                    w_state_nxt      = S_IDLE;
                    w_last_grant_nxt = c_LAST_D;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request and response paths are pure muxes keyed by the registered state,
    // so an asynchronous reset silences every output immediately.
    always_comb begin
        oreq_valid    = 1'b0;
        oreq_addr     = '0;
        oreq_size     = '0;
        oreq_strobe   = '0;
        oreq_data     = '0;
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        case (r_state)
            S_GRANT_I: begin
                oreq_valid    = 1'b1;
                oreq_addr     = ireq_addr;
                oreq_size     = ireq_size;
                iresp_addr_ok = oresp_addr_ok;
                iresp_data_ok = oresp_data_ok;
                iresp_data    = oresp_data;
            end
            S_GRANT_D: begin
                oreq_valid    = 1'b1;
                oreq_addr     = dreq_addr;
                oreq_size     = dreq_size;
                oreq_strobe   = dreq_strobe;
                oreq_data     = dreq_data;
                dresp_addr_ok = oresp_addr_ok;
                dresp_data_ok = oresp_data_ok;
                dresp_data    = oresp_data;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
//  Module   : tb_bus_arbiter
//  Purpose  : Directed, table-driven self-checking bench for bus_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_arbiter;

    typedef struct packed {
        logic        v;
        logic [63:0] a;
        logic [2:0]  sz;
        logic [7:0]  st;
        logic [63:0] d;
    } oreq_t;

    typedef struct packed {
        logic        aok;
        logic        dok;
        logic [63:0] d;
    } resp_t;

    typedef struct {
        string       name;
        logic        iv;
        logic        dv;
        logic        oaok;
        logic        odok;
        logic [63:0] odata;
        oreq_t       e_oreq;
        resp_t       e_i;
        resp_t       e_d;
    } vec_t;

    localparam logic [63:0] IA  = 64'h0000_0000_8000_0000;
    localparam logic [2:0]  IS  = 3'd2;
    localparam logic [63:0] DA  = 64'h0000_0000_8000_1000;
    localparam logic [2:0]  DS  = 3'd3;
    localparam logic [7:0]  DST = 8'hFF;
    localparam logic [63:0] DD  = 64'hDEAD_BEEF_0000_0001;

    localparam oreq_t OQ0 = '0;
    localparam oreq_t OQI = '{v: 1'b1, a: IA, sz: IS, st: 8'h00, d: 64'h0};
    localparam oreq_t OQD = '{v: 1'b1, a: DA, sz: DS, st: DST, d: DD};
    localparam resp_t R0  = '0;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic [2:0]  ireq_size;
    logic        iresp_addr_ok, iresp_data_ok;
    logic [63:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        oreq_valid;
    logic [63:0] oreq_addr;
    logic [2:0]  oreq_size;
    logic [7:0]  oreq_strobe;
    logic [63:0] oreq_data;
    logic        oresp_addr_ok, oresp_data_ok;
    logic [63:0] oresp_data;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .ireq_size     (ireq_size),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .oreq_valid    (oreq_valid),
        .oreq_addr     (oreq_addr),
        .oreq_size     (oreq_size),
        .oreq_strobe   (oreq_strobe),
        .oreq_data     (oreq_data),
        .oresp_addr_ok (oresp_addr_ok),
        .oresp_data_ok (oresp_data_ok),
        .oresp_data    (oresp_data)
    );

    function automatic void add(string n, logic iv, logic dv, logic oaok, logic odok,
                                logic [63:0] od, oreq_t eo, resp_t ei, resp_t ed);
        vec_t v;
        v.name = n; v.iv = iv; v.dv = dv; v.oaok = oaok; v.odok = odok; v.odata = od;
        v.e_oreq = eo; v.e_i = ei; v.e_d = ed;
        vecs.push_back(v);
    endfunction

    task automatic drive(logic iv, logic dv, logic oaok, logic odok, logic [63:0] od);
        ireq_valid    = iv;
        dreq_valid    = dv;
        oresp_addr_ok = oaok;
        oresp_data_ok = odok;
        oresp_data    = od;
    endtask

    task automatic chk_all(string n, oreq_t eo, resp_t ei, resp_t ed);
        oreq_t ao;
        resp_t ai, ad;
        ao = {oreq_valid, oreq_addr, oreq_size, oreq_strobe, oreq_data};
        ai = {iresp_addr_ok, iresp_data_ok, iresp_data};
        ad = {dresp_addr_ok, dresp_data_ok, dresp_data};
        n_checks++;
        if (ao !== eo) begin
            n_fail++;
            $display("FAIL %s oreq: got %h expected %h", n, ao, eo);
        end
        n_checks++;
        if (ai !== ei) begin
            n_fail++;
            $display("FAIL %s iresp: got %h expected %h", n, ai, ei);
        end
        n_checks++;
        if (ad !== ed) begin
            n_fail++;
            $display("FAIL %s dresp: got %h expected %h", n, ad, ed);
        end
    endtask

    initial begin
        //   name            iv dv aok dok data        oreq  iresp                   dresp
        add("fetch_req",      1, 0, 0, 0, 64'h0,   OQ0, R0, R0);
        add("fetch_grant",    1, 0, 0, 0, 64'h0,   OQI, R0, R0);
        add("fetch_wait",     1, 0, 0, 0, 64'h0,   OQI, R0, R0);
        add("fetch_done",     1, 0, 1, 1, 64'h13,  OQI, '{1'b1, 1'b1, 64'h13}, R0);
        add("fetch_idle",     0, 0, 0, 0, 64'h0,   OQ0, R0, R0);
        add("spurious",       0, 0, 1, 1, 64'h55,  OQ0, R0, R0);
        add("spurious_after", 0, 0, 0, 0, 64'h0,   OQ0, R0, R0);
        add("cont_req",       1, 1, 0, 0, 64'h0,   OQ0, R0, R0);
        add("cont_grant_d",   1, 1, 0, 0, 64'h0,   OQD, R0, R0);
        add("cont_done_d",    1, 1, 1, 1, 64'hAA,  OQD, R0, '{1'b1, 1'b1, 64'hAA});
        add("cont_bubble",    1, 1, 0, 0, 64'h0,   OQ0, R0, R0);
        add("cont_grant_i",   1, 1, 0, 0, 64'h0,   OQI, R0, R0);
        add("cont_done_i",    1, 1, 0, 1, 64'h13,  OQI, '{1'b0, 1'b1, 64'h13}, R0);
        add("cont_bubble2",   1, 1, 0, 0, 64'h0,   OQ0, R0, R0);
        add("cont_grant_d2",  1, 1, 0, 0, 64'h0,   OQD, R0, R0);
        add("cont_done_d2",   1, 1, 1, 1, 64'hBB,  OQD, R0, '{1'b1, 1'b1, 64'hBB});
        add("drop_req",       1, 0, 0, 0, 64'h0,   OQ0, R0, R0);
        add("drop_grant",     1, 0, 0, 0, 64'h0,   OQI, R0, R0);
        add("drop_addr_ok",   0, 0, 1, 0, 64'h77,  OQI, '{1'b1, 1'b0, 64'h77}, R0);
        add("drop_done",      0, 0, 0, 1, 64'h99,  OQI, '{1'b0, 1'b1, 64'h99}, R0);
        add("drop_idle",      0, 0, 0, 0, 64'h0,   OQ0, R0, R0);

        ireq_addr   = IA;
        ireq_size   = IS;
        dreq_addr   = DA;
        dreq_size   = DS;
        dreq_strobe = DST;
        dreq_data   = DD;

        // Reset with requests and a downstream response pending: all quiet.
        reset = 1'b0;
        drive(1, 1, 1, 1, 64'h42);
        #3;
        chk_all("reset_state", OQ0, R0, R0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 64'h0);

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].iv, vecs[k].dv, vecs[k].oaok, vecs[k].odok, vecs[k].odata);
            #1;
            chk_all(vecs[k].name, vecs[k].e_oreq, vecs[k].e_i, vecs[k].e_d);
        end

        // Complete a D transaction so last_grant=D, then reset mid-way through
        // a second one: afterwards contention must again favour D.
        @(negedge clk);
        drive(0, 1, 0, 0, 64'h0);
        #1;
        chk_all("wr_req", OQ0, R0, R0);
        @(negedge clk);
        drive(0, 1, 1, 1, 64'h11);
        #1;
        chk_all("wr_done", OQD, R0, '{1'b1, 1'b1, 64'h11});
        @(negedge clk);
        drive(0, 1, 0, 0, 64'h0);
        #1;
        chk_all("wr2_req", OQ0, R0, R0);
        @(negedge clk);
        #1;
        chk_all("wr2_grant", OQD, R0, R0);
        #1;
        drive(0, 1, 1, 1, 64'h66);
        reset = 1'b0;
        #1;
        chk_all("async_reset", OQ0, R0, R0);
        @(negedge clk);
        #1;
        chk_all("in_reset", OQ0, R0, R0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1, 0, 0, 64'h0);
        #1;
        chk_all("post_reset_req", OQ0, R0, R0);
        @(negedge clk);
        #1;
        chk_all("post_reset_grant_d", OQD, R0, R0);
        @(negedge clk);
        drive(1, 1, 1, 1, 64'h21);
        #1;
        chk_all("post_reset_done_d", OQD, R0, '{1'b1, 1'b1, 64'h21});
        @(negedge clk);
        drive(1, 1, 0, 0, 64'h0);
        @(negedge clk);
        #1;
        chk_all("post_reset_grant_i", OQI, R0, R0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
